// File: rtl/pll_phase_ctrl.sv
// PLL supervisor and dynamic phase-step controller: owns PLL RST, qualifies LOCK,
// retries on timeout when PLL_AUTO_RETRY_EN is defined, and sequences PHASE_STEP_N pulses.
module pll_phase_ctrl #(
  parameter int NUM_CH       = 3,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_FILT    = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STEP_W       = 8,
  parameter int STEP_GAP     = 4
) (
  input  logic              clkin1,
  input  logic              pll_rst,
  input  logic              pll_lock,
  output logic              pll_rst_o,
  output logic              locked,
  output logic              sys_rst,
  output logic              lock_fail,
  output logic [3:0]        retry_cnt,
  input  logic              ph_req,
  input  logic [2:0]        ph_ch,
  input  logic              ph_dir,
  input  logic [STEP_W-1:0] ph_steps,
  output logic              ph_ack,
  output logic              ph_busy,
  output logic              ph_done,
  output logic              ph_err,
  output logic [2:0]        phase_sel,
  output logic              phase_dir,
  output logic              phase_step_n
);

  localparam int CNT_MAX = (RST_HOLD > STEP_GAP) ? RST_HOLD : STEP_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FILT_W  = $clog2(LOCK_FILT + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STEP_GAP - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]        NUM_CH_L  = 4'(NUM_CH);

  typedef enum logic [2:0] {
    S_RESET, S_WAIT_LOCK, S_LOCKED, S_STEP_LO, S_STEP_GAP, S_FAIL
  } state_t;

`ifdef PLL_AUTO_RETRY_EN
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  logic              r_lock_meta, r_lock_s;
  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [FILT_W-1:0] r_filt, w_filt;
  logic [TMO_W-1:0]  r_tmo, w_tmo;
  logic              r_ack, w_ack, r_done, w_done, r_err, w_err;
  logic [2:0]        r_sel, w_sel;
  logic              r_dir, w_dir;
  logic              r_fail, w_fail;
  logic [3:0]        r_retry, w_retry;
  logic              r_step_n;
  logic [STEP_W-1:0] r_remain;
  logic              w_load, w_dec;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_filt  = r_filt;
    w_tmo   = r_tmo;
    w_ack   = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_sel   = r_sel;
    w_dir   = r_dir;
    w_fail  = r_fail;
    w_retry = r_retry;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    case (r_state)
      S_RESET: begin
        if (r_cnt == HOLD_LAST) begin
          w_state = S_WAIT_LOCK;
          w_filt  = '0;
          w_tmo   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        w_filt = r_lock_s ? r_filt + FILT_W'(1) : '0;
        w_tmo  = r_tmo + TMO_W'(1);
        if (r_lock_s && (r_filt == FILT_LAST)) begin
          w_state = S_LOCKED;
        end else if (r_tmo == TMO_LAST) begin
          w_fail = 1'b1;
`ifdef PLL_AUTO_RETRY_EN
          w_retry = sat_inc4(r_retry);
          w_state = S_RESET;
          w_cnt   = '0;
`else
          w_state = S_FAIL;
`endif
        end
      end
      S_LOCKED: begin
        if (!r_lock_s) begin
          w_state = S_RESET;
          w_cnt   = '0;
        end else if (ph_req) begin
          if ({1'b0, ph_ch} >= NUM_CH_L) begin
            w_err = 1'b1;
          end else if (ph_steps == '0) begin
            w_ack  = 1'b1;
            w_done = 1'b1;
          end else begin
            w_ack   = 1'b1;
            w_sel   = ph_ch;
            w_dir   = ph_dir;
            w_load  = 1'b1;
            w_state = S_STEP_LO;
          end
        end
      end
      S_STEP_LO: begin
        if (!r_lock_s) begin
          w_state = S_RESET;
          w_cnt   = '0;
          w_err   = 1'b1;
        end else begin
          w_state = S_STEP_GAP;
          w_cnt   = '0;
        end
      end
      S_STEP_GAP: begin
        if (!r_lock_s) begin
          w_state = S_RESET;
          w_cnt   = '0;
          w_err   = 1'b1;
        end else if (r_cnt == GAP_LAST) begin
          if (r_remain == STEP_W'(1)) begin
            w_state = S_LOCKED;
            w_done  = 1'b1;
          end else begin
            w_state = S_STEP_LO;
            w_dec   = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_FAIL: begin
        w_state = S_FAIL;
      end
      default: begin
        w_state = S_RESET;
        w_cnt   = '0;
      end
    endcase
  end

  // Register stage: synchroniser, FSM state, counters and pulse outputs
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= S_RESET;
      r_cnt       <= '0;
      r_filt      <= '0;
      r_tmo       <= '0;
      r_ack       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sel       <= 3'd0;
      r_dir       <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= 4'd0;
      r_step_n    <= 1'b1;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_filt      <= w_filt;
      r_tmo       <= w_tmo;
      r_ack       <= w_ack;
      r_done      <= w_done;
      r_err       <= w_err;
      r_sel       <= w_sel;
      r_dir       <= w_dir;
      r_fail      <= w_fail;
      r_retry     <= w_retry;
      // Low pulse trails STEP_LO by one cycle so it lands after the ack; a lock loss suppresses it
      r_step_n    <= ~((r_state == S_STEP_LO) & r_lock_s);
    end
  end

  always_ff @(posedge clkin1) begin
    if (w_load) begin
      r_remain <= ph_steps;
    end else if (w_dec) begin
      r_remain <= r_remain - STEP_W'(1);
    end
  end

  assign locked       = (r_state == S_LOCKED) || (r_state == S_STEP_LO) || (r_state == S_STEP_GAP);
  assign sys_rst      = ~locked;
  assign pll_rst_o    = (r_state == S_RESET) || (r_state == S_FAIL);
  assign ph_busy      = (r_state == S_STEP_LO) || (r_state == S_STEP_GAP);
  assign ph_ack       = r_ack;
  assign ph_done      = r_done;
  assign ph_err       = r_err;
  assign phase_sel    = r_sel;
  assign phase_dir    = r_dir;
  assign phase_step_n = r_step_n;
  assign lock_fail    = r_fail;
  assign retry_cnt    = r_retry;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: directed bring-up, glitch, loss and timeout steps plus
// randomized phase-step requests checked against a cycle-position model.
module tb_pll_phase_ctrl;
  localparam int NUM_CH       = 3;
  localparam int RST_HOLD     = 16;
  localparam int LOCK_FILT    = 16;
  localparam int LOCK_TIMEOUT = 64;
  localparam int STEP_W       = 8;
  localparam int STEP_GAP     = 4;
  localparam int PER          = 1 + STEP_GAP;

  logic              clkin1 = 1'b0;
  logic              pll_rst, pll_lock;
  logic              pll_rst_o, locked, sys_rst, lock_fail;
  logic [3:0]        retry_cnt;
  logic              ph_req, ph_dir;
  logic [2:0]        ph_ch;
  logic [STEP_W-1:0] ph_steps;
  logic              ph_ack, ph_busy, ph_done, ph_err;
  logic [2:0]        phase_sel;
  logic              phase_dir, phase_step_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int req_id = 0;

  always #5 clkin1 = ~clkin1;

  pll_phase_ctrl #(
    .NUM_CH(NUM_CH), .RST_HOLD(RST_HOLD), .LOCK_FILT(LOCK_FILT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .STEP_W(STEP_W), .STEP_GAP(STEP_GAP)
  ) dut (
    .clkin1(clkin1), .pll_rst(pll_rst), .pll_lock(pll_lock),
    .pll_rst_o(pll_rst_o), .locked(locked), .sys_rst(sys_rst),
    .lock_fail(lock_fail), .retry_cnt(retry_cnt),
    .ph_req(ph_req), .ph_ch(ph_ch), .ph_dir(ph_dir), .ph_steps(ph_steps),
    .ph_ack(ph_ack), .ph_busy(ph_busy), .ph_done(ph_done), .ph_err(ph_err),
    .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clkin1);
    #1;
    cyc++;
  endtask

  // Issue one request and compare every cycle of the response against where the
  // handshake rules place ack/err/done, the busy window and the low pulses.
  task automatic do_req(input int ch, input int dir, input int steps);
    logic       t_ack [1:64], t_done [1:64], t_err [1:64], t_busy [1:64], t_stn [1:64], t_dir [1:64];
    logic [2:0] t_sel [1:64];
    int  w, m_ack, m_done, m_err, m_busy, m_stn, m_sel;
    bit  valid, e_lo;
    string id;
    w = PER * steps + 4;
    ph_ch    = 3'(ch);
    ph_dir   = 1'(dir);
    ph_steps = STEP_W'(steps);
    ph_req   = 1'b1;
    for (int i = 1; i <= w; i++) begin
      tick();
      if (i == 1) ph_req = 1'b0;
      t_ack[i]  = ph_ack;
      t_done[i] = ph_done;
      t_err[i]  = ph_err;
      t_busy[i] = ph_busy;
      t_stn[i]  = phase_step_n;
      t_sel[i]  = phase_sel;
      t_dir[i]  = phase_dir;
    end
    valid = (ch < NUM_CH);
    m_ack = 0; m_done = 0; m_err = 0; m_busy = 0; m_stn = 0; m_sel = 0;
    for (int i = 1; i <= w; i++) begin
      if (t_ack[i]  !== (valid && i == 1))              m_ack++;
      if (t_err[i]  !== (!valid && i == 1))             m_err++;
      if (t_done[i] !== (valid && i == 1 + PER * steps)) m_done++;
      if (t_busy[i] !== (valid && i <= PER * steps))     m_busy++;
      e_lo = valid && (i >= 2) && ((i - 2) % PER == 0) && ((i - 2) / PER < steps);
      if (t_stn[i] !== !e_lo) m_stn++;
      if (valid && steps > 0 && i <= 1 + PER * steps &&
          (t_sel[i] !== 3'(ch) || t_dir[i] !== 1'(dir))) m_sel++;
    end
    id = $sformatf("req%0d(ch=%0d,dir=%0d,n=%0d)", req_id, ch, dir, steps);
    req_id++;
    chk({id, "_ack_cycles_wrong"},   m_ack,  0);
    chk({id, "_err_cycles_wrong"},   m_err,  0);
    chk({id, "_done_cycles_wrong"},  m_done, 0);
    chk({id, "_busy_cycles_wrong"},  m_busy, 0);
    chk({id, "_stepn_cycles_wrong"}, m_stn,  0);
    chk({id, "_seldir_cycles_wrong"}, m_sel, 0);
  endtask

  initial begin
    int n, n_lo, e_lo;
    pll_rst  = 1'b1;
    pll_lock = 1'b0;
    ph_req   = 1'b0;
    ph_ch    = 3'd0;
    ph_dir   = 1'b0;
    ph_steps = '0;
    repeat (3) tick();
    chk("rst_pll_rst_o", pll_rst_o, 1);
    chk("rst_locked", locked, 0);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_lock_fail", lock_fail, 0);
    chk("rst_retry_cnt", retry_cnt, 0);
    chk("rst_ph_flags", {ph_ack, ph_busy, ph_done, ph_err}, 0);
    chk("rst_phase_sel", phase_sel, 0);
    chk("rst_phase_dir", phase_dir, 0);
    chk("rst_phase_step_n", phase_step_n, 1);

    // Power-up: reset hold, then lock asserted at cycle 40
    pll_rst = 1'b0;
    cyc = 0;
    n = 0;
    while (pll_rst_o === 1'b1 && n < 100) begin n++; tick(); end
    chk("powerup_rst_hold", n, RST_HOLD);
    while (cyc < 40) tick();
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 100) begin tick(); n++; end
    chk_rng("powerup_lock_latency", n, 1 + LOCK_FILT, 3 + LOCK_FILT);
    chk("powerup_sys_rst", sys_rst, 0);

    // Idle lock loss, then a one-cycle glitch mid-filter
    pll_lock = 1'b0;
    n = 0;
    while (locked === 1'b1 && n < 20) begin tick(); n++; end
    chk("idle_loss_latency", n, 3);
    chk("idle_loss_no_err", ph_err, 0);
    n = 0;
    while (pll_rst_o === 1'b1 && n < 100) begin n++; tick(); end
    chk("idle_loss_rst_hold", n, RST_HOLD);
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (8) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 100) begin tick(); n++; end
    chk_rng("glitch_relock_latency", n, 1 + LOCK_FILT, 3 + LOCK_FILT);

    // Directed requests, then randomized ones
    do_req(2, 1, 3);
    do_req(5, 0, 2);
    do_req(1, 0, 0);
    do_req(0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      do_req(int'($urandom_range(0, 4)), int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Lock loss while stepping: 4 steps requested, lock dropped at relative cycle 6
    ph_ch = 3'd0; ph_dir = 1'b1; ph_steps = STEP_W'(4); ph_req = 1'b1;
    n_lo = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) ph_req = 1'b0;
      if (phase_step_n === 1'b0) n_lo++;
    end
    pll_lock = 1'b0;
    n = 0;
    while (ph_err !== 1'b1 && n < 20) begin
      tick(); n++;
      if (phase_step_n === 1'b0) n_lo++;
    end
    chk("step_loss_err_latency", n, 3);
    e_lo = 0;
    for (int k = 0; k < 4; k++) if (2 + PER * k < 6 + 3) e_lo++;
    chk("step_loss_pulse_count", n_lo, e_lo);
    chk("step_loss_step_n", phase_step_n, 1);
    chk("step_loss_busy", ph_busy, 0);
    chk("step_loss_sys_rst", sys_rst, 1);
    chk("step_loss_pll_rst_o", pll_rst_o, 1);
    n = 0;
    while (pll_rst_o === 1'b1 && n < 100) begin n++; tick(); end
    chk("step_loss_rst_hold", n, RST_HOLD);
    chk("step_loss_no_retry", retry_cnt, 0);

    // Timeout with lock held low
    repeat (LOCK_TIMEOUT - 1) tick();
    chk("tmo_before_pll_rst_o", pll_rst_o, 0);
    chk("tmo_before_lock_fail", lock_fail, 0);
    tick();
    chk("tmo_lock_fail", lock_fail, 1);
    chk("tmo_pll_rst_o", pll_rst_o, 1);
    chk("tmo_sys_rst", sys_rst, 1);
`ifdef PLL_AUTO_RETRY_EN
    chk("tmo_retry_first", retry_cnt, 1);
    n = 0;
    while (retry_cnt !== 4'd2 && n < 300) begin tick(); n++; end
    chk("tmo_retry_period", n, RST_HOLD + LOCK_TIMEOUT);
    repeat (14 * (RST_HOLD + LOCK_TIMEOUT) + 40) tick();
    chk("tmo_retry_saturated", retry_cnt, 15);
    chk("tmo_lock_fail_sticky", lock_fail, 1);
`else
    chk("tmo_retry_zero", retry_cnt, 0);
    repeat (200) tick();
    chk("fail_hold_pll_rst_o", pll_rst_o, 1);
    chk("fail_hold_sys_rst", sys_rst, 1);
    chk("fail_hold_lock_fail", lock_fail, 1);
    chk("fail_hold_retry_zero", retry_cnt, 0);
`endif

    // Asynchronous reset between clock edges
    #2;
    pll_rst = 1'b1;
    #1;
    chk("async_rst_lock_fail", lock_fail, 0);
    chk("async_rst_retry_cnt", retry_cnt, 0);
    chk("async_rst_pll_rst_o", pll_rst_o, 1);
    chk("async_rst_sys_rst", sys_rst, 1);
    chk("async_rst_step_n", phase_step_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Supervisor and dynamic phase-step controller for the GTP_PLL_E3 primitive wrapped by the team's PLL IP. It owns the PLL's RST input and qualifies LOCK. It issues a system reset for downstream logic, retries the PLL on lock timeout, and converts a simple request handshake into PHASE_SEL / PHASE_DIR / PHASE_STEP_N step sequences for up to five output channels. It runs on the free-running PLL reference clock and sits between the board-level reset and the PLL wrapper.

## Interface
- NUM_CH, 3: number of steppable outputs, 1..5.
- RST_HOLD, 16: cycles pll_rst_o is held high per reset attempt, ≥2.
- LOCK_FILT, 1024: consecutive synced-high lock cycles required to qualify lock.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before timeout.
- STEP_W, 8: width of ph_steps.
- STEP_GAP, 4: high cycles of phase_step_n after each low pulse, ≥1.

Ports:
- clkin1  in  1  reference clock, also the PLL input clock.
- pll_rst  in  1  reset; asynchronous, active-high.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clkin1.
- pll_rst_o  out  1  drives PLL RST.
- locked  out  1  qualified lock.
- sys_rst  out  1  active-high downstream reset, equal to ~locked.
- lock_fail  out  1  sticky timeout flag.
- retry_cnt  out  4  saturating count of timeout retries.
- ph_req  in  1  step request, level.
- ph_ch  in  3  target channel.
- ph_dir  in  1  step direction.
- ph_steps  in  STEP_W  number of steps.
- ph_ack  out  1  one-cycle accept pulse.
- ph_busy  out  1  stepping in progress.
- ph_done  out  1  one-cycle completion pulse.
- ph_err  out  1  one-cycle reject/abort pulse.
- phase_sel  out  3  to PLL PHASE_SEL.
- phase_dir  out  1  to PLL PHASE_DIR.
- phase_step_n  out  1  to PLL PHASE_STEP_N, active-low.

## Operation
- Reset values: pll_rst_o=1, locked=0, sys_rst=1, lock_fail=0, retry_cnt=0, ph_ack/ph_busy/ph_done/ph_err=0, phase_sel=0, phase_dir=0, phase_step_n=1.
- pll_lock passes through a 2-FF synchroniser (lock_s). All decisions use lock_s.
- States:
  - RESET: pll_rst_o=1 for RST_HOLD cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst_o=0. The filter counter increments while lock_s=1 and clears on any lock_s=0. At LOCK_FILT, go to LOCKED. The timeout counter hits LOCK_TIMEOUT → timeout handling (see Configuration).
  - LOCKED: locked=1. Accepts requests.
  - STEP_LO: phase_step_n=0 for one cycle.
  - STEP_GAP: phase_step_n=1 for STEP_GAP cycles. Decrement the remaining count. Go to STEP_LO if nonzero, else emit ph_done and return to LOCKED.
  - FAIL: only when the retry macro is absent.
- Request accept, in LOCKED with ph_req=1:
  - ph_ch<NUM_CH and ph_steps≠0: latch phase_sel=ph_ch and phase_dir=ph_dir, pulse ph_ack, set ph_busy, enter STEP_LO next cycle.
  - ph_ch≥NUM_CH: pulse ph_err, no step.
  - ph_steps=0: pulse ph_ack and ph_done together, no step.
- Requests arriving outside LOCKED are ignored. ph_ack is not pulsed; the requester holds ph_req.
- Lock loss (lock_s=0) in LOCKED/STEP_LO/STEP_GAP:
  - Next cycle: locked=0, sys_rst=1, phase_step_n=1, ph_busy=0.
  - If stepping, pulse ph_err.
  - Enter RESET. A lock loss is not counted as a retry.
- retry_cnt saturates at 15. lock_fail clears only on pll_rst.
- Asynchronous pll_rst mid-operation returns every output to its reset value immediately.

## Timing
- Lock qualification: locked rises 2 + LOCK_FILT cycles after pll_lock stably rises, within ±1 cycle of synchroniser uncertainty.
- Request latency: ph_ack in the cycle after ph_req is sampled. The first phase_step_n low occurs the cycle after ph_ack.
- Step sequence: busy for N×(1+STEP_GAP) cycles. ph_done is asserted in the cycle after the last gap cycle, coincident with ph_busy falling.
- phase_sel and phase_dir are stable from ph_ack until ph_done.
- A ph_req held high through ph_done is accepted again no earlier than 1 cycle after ph_done.

## Configuration
- PLL_AUTO_RETRY_EN defined: on timeout, increment retry_cnt, set lock_fail, and go to RESET (retry indefinitely).
- PLL_AUTO_RETRY_EN undefined: on timeout, set lock_fail and go to FAIL. pll_rst_o=1 and sys_rst=1 are held until pll_rst. retry_cnt stays 0.

## Test plan
- Power-up: release pll_rst, assert pll_lock at cycle 40 (LOCK_FILT=16). Expect pll_rst_o low after 16 cycles, locked=1 and sys_rst=0 at cycle 58±1.
- Lock glitch: drop pll_lock for 1 cycle mid-filter. Expect the filter to restart and locked delayed by the full LOCK_FILT.
- Step: ph_ch=2, ph_dir=1, ph_steps=3, STEP_GAP=4. Expect phase_sel=2, phase_dir=1, exactly 3 low pulses spaced 5 cycles apart, and ph_done 15 cycles after ph_ack.
- Reject: ph_ch=5 with NUM_CH=3 → ph_err pulse, no phase_step_n activity. ph_steps=0 → ph_ack and ph_done in the same cycle.
- Lock loss during step 2 of 4: expect phase_step_n=1, ph_err pulse, sys_rst=1, and pll_rst_o=1 for RST_HOLD cycles.
- Timeout (LOCK_TIMEOUT=64, pll_lock held 0): with the macro, retry_cnt increments every 16+64 cycles and saturates at 15. Without it, lock_fail=1, FAIL is entered, and pll_rst_o stays 1.
